// File: rtl/microcode_phase_sequencer.sv
// Steps a microcode word's enabled phases RD/EX/MEM/WB, stalling in MEM until ack.
// Optional MEM watchdog enabled by defining MEM_TIMEOUT_EN.
module microcode_phase_sequencer #(
  parameter int MW             = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uword_valid,
  output logic          uword_ready,
  input  logic [MW-1:0] uword_in,
  output logic [3:0]    phase,
  output logic [MW-5:0] ctrl_out,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          retire,
  output logic          err,
  output logic [31:0]   retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EX,
    S_MEM,
    S_WB
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mask_q, mask_d;
  logic [MW-5:0] ctrl_q, ctrl_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q;
  logic [3:0]    new_mask;
  logic [3:0]    above;
  logic          done;
  logic          last;
  logic          tmo;

  function automatic state_t first_of(
    input logic [3:0] m
  );
    if (m[0])      return S_RD;
    else if (m[1]) return S_EX;
    else if (m[2]) return S_MEM;
    else if (m[3]) return S_WB;
    else           return S_IDLE;
  endfunction

  assign new_mask = uword_in[MW-1:MW-4];

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_q;

  // Counter rests at 0 outside MEM, so it is clear on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (state_q != S_MEM) begin
      tmo_q <= '0;
    end else if (!mem_ack) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  assign tmo = (state_q == S_MEM) && !mem_ack &&
               (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo        = 1'b0;
`endif

  always_comb begin
    above = 4'b0000;
    done  = 1'b0;
    phase = 4'b0000;
    unique case (state_q)
      S_RD: begin
        above = mask_q & 4'b1110;
        done  = 1'b1;
        phase = 4'b0001;
      end
      S_EX: begin
        above = mask_q & 4'b1100;
        done  = 1'b1;
        phase = 4'b0010;
      end
      S_MEM: begin
        above = mask_q & 4'b1000;
        done  = mem_ack;
        phase = 4'b0100;
      end
      S_WB: begin
        done  = 1'b1;
        phase = 4'b1000;
      end
      default: ;
    endcase
  end

  assign last = (above == 4'b0000);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ctrl_d  = ctrl_q;
    err_d   = 1'b0;
    retire  = 1'b0;
    if (state_q == S_IDLE) begin
      if (uword_valid) begin
        if (new_mask == 4'b0000) begin
          err_d = 1'b1;
        end else begin
          state_d = first_of(new_mask);
          mask_d  = new_mask;
          ctrl_d  = uword_in[MW-5:0];
        end
      end
    end else if (tmo) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      ctrl_d  = '0;
    end else if (done) begin
      state_d = first_of(above);
      if (last) begin
        retire = 1'b1;
        ctrl_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      if (retire) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign uword_ready = (state_q == S_IDLE);
  assign mem_req     = (state_q == S_MEM);
  assign ctrl_out    = ctrl_q;
  assign err         = err_q;
  assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_microcode_phase_sequencer.sv
// Bench for microcode_phase_sequencer: vector table, hand sequences, random vs model.
// Define MEM_TIMEOUT_EN to also exercise the MEM watchdog (limit 4).
module tb_microcode_phase_sequencer;
  localparam int MW  = 64;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          uword_valid = 1'b0;
  logic          mem_ack = 1'b0;
  logic [MW-1:0] uword_in = '0;
  logic          uword_ready;
  logic [3:0]    phase;
  logic [MW-5:0] ctrl_out;
  logic          mem_req;
  logic          retire;
  logic          err;
  logic [31:0]   retire_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic seen_retire;
  logic seen_err;

  always #5 clk = ~clk;

  microcode_phase_sequencer #(
    .MW(MW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uword_valid(uword_valid),
    .uword_ready(uword_ready),
    .uword_in(uword_in),
    .phase(phase),
    .ctrl_out(ctrl_out),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .retire(retire),
    .err(err),
    .retire_cnt(retire_cnt)
  );

  // Reference model: pending phase list of the current instruction.
  int            q[$];
  bit            busy;
  bit            err_p;
  int            wait_n;
  logic [MW-5:0] m_ctrl;
  logic [31:0]   m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      busy = 0; err_p = 0; wait_n = 0;
      m_ctrl = '0; m_cnt = 0;
    end else if (!busy) begin
      err_p = 0;
      if (uword_valid) begin
        for (int i = 0; i < 4; i++)
          if (uword_in[MW-4+i]) q.push_back(i);
        if (q.size() == 0) err_p = 1;
        else begin
          busy = 1;
          m_ctrl = uword_in[MW-5:0];
          wait_n = 0;
        end
      end
    end else begin
      if (q[0] == 2 && !mem_ack) begin
        wait_n++;
`ifdef MEM_TIMEOUT_EN
        if (wait_n == TMO) begin
          q.delete();
          busy = 0; err_p = 1; m_ctrl = '0;
        end
`endif
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          busy = 0; m_ctrl = '0;
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  task automatic cmp(string tag, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check(string tag);
    logic [3:0] ph_e;
    logic mr_e, rt_e, er_e, rd_e;
    logic [MW-5:0] ct_e;
    ph_e = 4'b0; mr_e = 0; rt_e = 0;
    ct_e = '0;
    if (busy) begin
      ph_e = 4'b0001 << q[0];
      mr_e = (q[0] == 2);
      rt_e = (q[0] != 2 || mem_ack) && q.size() == 1;
      ct_e = m_ctrl;
    end
    er_e = !busy && err_p;
    rd_e = !busy;
    cmp(tag,
        {rd_e, ph_e, ct_e, mr_e, rt_e, er_e, m_cnt},
        {uword_ready, phase, ctrl_out, mem_req, retire, err, retire_cnt});
  endtask

  // Called just after a rising edge; inputs hold for that cycle.
  task automatic cyc(logic v, logic [MW-1:0] w, logic a, string tag);
    uword_valid = v;
    uword_in = w;
    mem_ack = a;
    @(negedge clk);
    seen_retire = retire;
    seen_err = err;
    check(tag);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [59:0] ctrl;
    int          ack_at;
    int          exp_len;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic apply(int i);
    int len, mc;
    bit e, a;
    len = 0; mc = 0; e = 0;
    cyc(1, {tbl[i].mask, tbl[i].ctrl}, 0, "accept");
    for (int k = 1; k <= 20; k++) begin
      a = busy && q[0] == 2 && (mc + 1 == tbl[i].ack_at);
      if (busy && q[0] == 2) mc++;
      cyc(0, {$urandom, $urandom}, a, "run");
      if (seen_retire) begin len = k; break; end
      if (seen_err) begin e = 1; break; end
    end
    cmp($sformatf("len_%0d", i), 128'(len), 128'(tbl[i].exp_len));
    cmp($sformatf("err_%0d", i), 128'(e), 128'(tbl[i].exp_err));
    cyc(0, '0, 0, "gap");
  endtask

  initial begin
    tbl[0] = '{4'b1011, 60'h123, 0, 3, 0};
    tbl[1] = '{4'b1111, 60'hABCDE, 3, 6, 0};
    tbl[2] = '{4'b0100, 60'h55, 1, 1, 0};
    tbl[3] = '{4'b0000, 60'h77, 0, 0, 1};
    tbl[4] = '{4'b1000, 60'hFFF, 0, 1, 0};
    tbl[5] = '{4'b0110, 60'h1, 2, 3, 0};
    tbl[6] = '{4'b1100, 60'h9, 4, 5, 0};
    tbl[7] = '{4'b0001, 60'hFFFFFFFFFFFFFFF, 0, 1, 0};

    #1;
    check("reset");
    cmp("reset_out", {uword_ready, phase, mem_req, retire, err},
        {1'b1, 4'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) apply(i);
    cmp("cnt_tbl", 128'(retire_cnt), 128'(7));

    // Reset asserted during EX of a full-mask word.
    cyc(1, {4'b1111, 60'h321}, 0, "r_acc");
    cyc(0, '0, 0, "r_rd");
    cmp("r_ex", 128'(phase), 128'(4'b0010));
    #2 reset = 1'b0;
    #1;
    check("r_async");
    cmp("r_out", {uword_ready, phase, ctrl_out, mem_req, retire_cnt},
        {1'b1, 4'b0, 60'h0, 1'b0, 32'h0});
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    apply(1);

`ifdef MEM_TIMEOUT_EN
    cyc(1, {4'b0100, 60'hAA}, 0, "t_acc");
    for (int k = 0; k < 4; k++) cyc(0, '0, 0, "t_wait");
    uword_valid = 0;
    @(negedge clk);
    cmp("t_err", {err, mem_req, uword_ready, retire, phase},
        {1'b1, 1'b0, 1'b1, 1'b0, 4'b0});
    check("t_post");
    @(posedge clk);
    #1;
    cyc(1, {4'b0100, 60'hBB}, 0, "t2_acc");
    for (int k = 0; k < 3; k++) cyc(0, '0, 0, "t2_wait");
    mem_ack = 1;
    @(negedge clk);
    cmp("t2_ret", {retire, err, phase}, {1'b1, 1'b0, 4'b0100});
    check("t2_last");
    @(posedge clk);
    #1;
    cyc(0, '0, 0, "t2_after");
    cmp("t2_noerr", 128'(err), 128'(0));
`endif

    for (int n = 0; n < 3000; n++)
      cyc(1'($urandom % 2), {$urandom, $urandom},
          1'($urandom % 3 == 0), "rand");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
